id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline buffer of the 5-stage core, directly upstream of the forwarding-control and EX operand muxes.
- Captures decoded fields from ID and presents them to EX; these are the opcode, rs1/rs2/rd, operand data, immediate and writeback select.
- Detects load-use hazards that forwarding cannot cover, holds IF/ID for one cycle and injects a bubble.
- Applies branch flush and downstream stall, and counts load-use bubbles.

Parameters:
- XLEN, 32, operand/immediate/PC width
- ALU_CTRL_W, 4, width of the ALU control field carried through
- CNT_W, 16, width of the saturating load-use bubble counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid_ip  in  1  ID holds a real instruction
- id_opcode_ip  in  7  decoded opcode (CORE_PKG OPCODE_*)
- id_rs1_ip / id_rs2_ip / id_rd_ip  in  5 each  register indices
- id_rs1_data_ip / id_rs2_data_ip  in  XLEN each  register-file read data
- id_imm_ip  in  XLEN  sign-extended immediate
- id_pc_ip  in  XLEN  instruction PC
- id_alu_ctrl_ip  in  ALU_CTRL_W  ALU operation
- id_wb_mux_ip  in  write_back_mux_selector  writeback source
- ex_flush_ip  in  1  branch/jump redirect from EX; kill ID->EX transfer
- mem_stall_ip  in  1  downstream stall; freeze this register
- ex_valid_op  out  1  EX slot valid
- ex_opcode_op, ex_rs1_op, ex_rs2_op, ex_rd_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op, ex_alu_ctrl_op, ex_wb_mux_op  out  matching widths  registered copies; opcode/rs1/rs2 feed the forwarding control
- id_hold_op  out  1  combinational; hold PC and IF/ID this cycle
- load_use_cnt_op  out  CNT_W  saturating count of injected bubbles

Behaviour:
- Reset (sync, highest priority):
  - Every ex_* output takes the bubble value: valid=0, opcode=7'b0, rs1=rs2=rd=0, data/imm/pc=0, alu_ctrl=0, wb_mux=NO_WRITEBACK.
  - load_use_cnt_op=0.
  - id_hold_op is 0 while reset is high.
- Register usage by opcode:
  - rs1 used by OPCODE_OP, OPIMM, LOAD, STORE, BRANCH, JALR.
  - rs2 used by OPCODE_OP, STORE, BRANCH.
  - All other opcodes use neither.
- load_use (combinational) is asserted when all of the following hold:
  - ex_valid_op is 1.
  - ex_wb_mux_op is MEM_WRITEBACK.
  - ex_rd_op is not 0.
  - id_valid_ip is 1.
  - A used source index equals ex_rd_op.
  - x0 never causes a hazard.
- id_hold_op = load_use | mem_stall_ip, gated to 0 when ex_flush_ip is 1.
- Per-edge update, in priority order:
  1. reset → bubble.
  2. ex_flush_ip → bubble, even if mem_stall_ip is 1. A flush kills the ID instruction.
  3. mem_stall_ip → hold all ex_* unchanged. Load-use is not evaluated for bubble injection in this case.
  4. load_use → bubble; load_use_cnt_op += 1, saturating at all-ones.
  5. Otherwise load the ID fields. ex_valid_op = id_valid_ip. An invalid ID instruction loads as a bubble, with wb_mux forced to NO_WRITEBACK.
- Latency:
  - ID→EX is 1 cycle.
  - Load-use costs exactly 1 bubble. After the bubble the load is in MEM and its consumer enters EX when the load reaches WB, where MEM/WB forwarding supplies the data.
  - The bubble in EX cannot retrigger load_use (valid=0), so there is no repeated stall.
- Bubble encoding is fixed (opcode 0, wb NO_WRITEBACK) so downstream forwarding selects ORIGINAL_SELECT and no register write occurs.
- Counter:
  - Counts only injected load-use bubbles, not mem stalls or flushes.
  - Holds at 2^CNT_W−1.

Decomposition:
- CORE_PKG holds the OPCODE_* constants and write_back_mux_selector, which includes NO_WRITEBACK and MEM_WRITEBACK.
- Add to CORE_PKG:
  - a packed struct id_ex_bundle_t holding every carried field
  - a function id_ex_bubble() returning the bubble value
- One sub-module: hazard_detect, the combinational load-use detector with its opcode-usage decode. It is instantiated once.

Test Plan:
- reset held 2 cycles with id_valid_ip=1 → ex_valid_op=0, ex_wb_mux_op=NO_WRITEBACK, load_use_cnt_op=0; first edge after release loads ID fields.
- EX: LOAD rd=5; ID: OP rs1=5, rs2=7 → id_hold_op=1 that cycle; next cycle ex_valid_op=0, cnt=1; following cycle OP enters EX with rs1=5.
- EX: LOAD rd=0; ID: OP rs1=0 → id_hold_op=0, no bubble. Also EX: LOAD rd=6; ID: OPIMM rs2 field=6, rs1=1 → no hazard, since OPIMM ignores rs2.
- ex_flush_ip=1 together with load_use=1 and mem_stall_ip=1 → next cycle bubble, id_hold_op=0, cnt unchanged.
- mem_stall_ip=1 for 3 cycles with changing ID inputs → ex_* stable across all 3, then the ID value present on release loads.
- CNT_W=2, 5 consecutive load-use events → load_use_cnt_op sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Core-wide opcode constants, writeback selector and the ID/EX bundle.
// Shared by the ID/EX register and its hazard detector.
package id_ex_stage_reg_pkg;

  localparam int CORE_XLEN       = 32;
  localparam int CORE_ALU_CTRL_W = 4;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    NO_WRITEBACK  = 2'd0,
    ALU_WRITEBACK = 2'd1,
    MEM_WRITEBACK = 2'd2,
    PC4_WRITEBACK = 2'd3
  } write_back_mux_selector;

  typedef struct packed {
    logic                       valid;
    logic [6:0]                 opcode;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [CORE_XLEN-1:0]       rs1_data;
    logic [CORE_XLEN-1:0]       rs2_data;
    logic [CORE_XLEN-1:0]       imm;
    logic [CORE_XLEN-1:0]       pc;
    logic [CORE_ALU_CTRL_W-1:0] alu_ctrl;
    write_back_mux_selector     wb_mux;
  } id_ex_bundle_t;

  function automatic id_ex_bundle_t id_ex_bubble();
    id_ex_bundle_t b;
    b        = '0;
    b.wb_mux = NO_WRITEBACK;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use detector: a load in EX whose rd feeds a source
// actually read by the instruction sitting in ID.
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic                   ex_valid,
  input  write_back_mux_selector ex_wb_mux,
  input  logic [4:0]             ex_rd,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  output logic                   load_use
);

  logic use_rs1;
  logic use_rs2;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      (id_opcode == OPCODE_OP),
      (id_opcode == OPCODE_STORE),
      (id_opcode == OPCODE_BRANCH): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      (id_opcode == OPCODE_OPIMM),
      (id_opcode == OPCODE_LOAD),
      (id_opcode == OPCODE_JALR): begin
        use_rs1 = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

  assign rs1_hit = use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never hazards
  assign load_use = ex_valid
                 && (ex_wb_mux == MEM_WRITEBACK)
                 && (ex_rd != 5'd0)
                 && id_valid
                 && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble injection,
// branch flush, downstream stall and a saturating bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_opcode_ip,
  input  logic [4:0]             id_rs1_ip,
  input  logic [4:0]             id_rs2_ip,
  input  logic [4:0]             id_rd_ip,
  input  logic [XLEN-1:0]        id_rs1_data_ip,
  input  logic [XLEN-1:0]        id_rs2_data_ip,
  input  logic [XLEN-1:0]        id_imm_ip,
  input  logic [XLEN-1:0]        id_pc_ip,
  input  logic [ALU_CTRL_W-1:0]  id_alu_ctrl_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  input  logic                   ex_flush_ip,
  input  logic                   mem_stall_ip,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_opcode_op,
  output logic [4:0]             ex_rs1_op,
  output logic [4:0]             ex_rs2_op,
  output logic [4:0]             ex_rd_op,
  output logic [XLEN-1:0]        ex_rs1_data_op,
  output logic [XLEN-1:0]        ex_rs2_data_op,
  output logic [XLEN-1:0]        ex_imm_op,
  output logic [XLEN-1:0]        ex_pc_op,
  output logic [ALU_CTRL_W-1:0]  ex_alu_ctrl_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic                   id_hold_op,
  output logic [CNT_W-1:0]       load_use_cnt_op
);

  if (XLEN != CORE_XLEN || ALU_CTRL_W != CORE_ALU_CTRL_W) begin : g_bad_width
    $error("id_ex_stage_reg: widths must match id_ex_bundle_t");
  end

  id_ex_bundle_t    ex_q;
  id_ex_bundle_t    id_d;
  logic             load_use;
  logic [CNT_W-1:0] cnt_q;

  hazard_detect u_hazard (
    .ex_valid  (ex_q.valid),
    .ex_wb_mux (ex_q.wb_mux),
    .ex_rd     (ex_q.rd),
    .id_valid  (id_valid_ip),
    .id_opcode (id_opcode_ip),
    .id_rs1    (id_rs1_ip),
    .id_rs2    (id_rs2_ip),
    .load_use  (load_use)
  );

  // An invalid ID slot enters EX as the canonical bubble
  always_comb begin
    id_d = id_ex_bubble();
    if (id_valid_ip) begin
      id_d.valid    = 1'b1;
      id_d.opcode   = id_opcode_ip;
      id_d.rs1      = id_rs1_ip;
      id_d.rs2      = id_rs2_ip;
      id_d.rd       = id_rd_ip;
      id_d.rs1_data = id_rs1_data_ip;
      id_d.rs2_data = id_rs2_data_ip;
      id_d.imm      = id_imm_ip;
      id_d.pc       = id_pc_ip;
      id_d.alu_ctrl = id_alu_ctrl_ip;
      id_d.wb_mux   = id_wb_mux_ip;
    end
  end

  assign id_hold_op = !reset && !ex_flush_ip
                   && (load_use || mem_stall_ip);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= id_ex_bubble();
      cnt_q <= '0;
    end else if (ex_flush_ip) begin
      ex_q <= id_ex_bubble();
    end else if (!mem_stall_ip) begin
      if (load_use) begin
        ex_q <= id_ex_bubble();
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        ex_q <= id_d;
      end
    end
  end

  assign ex_valid_op     = ex_q.valid;
  assign ex_opcode_op    = ex_q.opcode;
  assign ex_rs1_op       = ex_q.rs1;
  assign ex_rs2_op       = ex_q.rs2;
  assign ex_rd_op        = ex_q.rd;
  assign ex_rs1_data_op  = ex_q.rs1_data;
  assign ex_rs2_data_op  = ex_q.rs2_data;
  assign ex_imm_op       = ex_q.imm;
  assign ex_pc_op        = ex_q.pc;
  assign ex_alu_ctrl_op  = ex_q.alu_ctrl;
  assign ex_wb_mux_op    = ex_q.wb_mux;
  assign load_use_cnt_op = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed scenarios plus
// random traffic against a rule-level model of the EX slot.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [31:0] id_d1, id_d2, id_imm, id_pc;
  logic [3:0] id_alu;
  write_back_mux_selector id_wb;
  logic flush, stall;

  logic ex_valid;
  logic [6:0] ex_opcode;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm, ex_pc;
  logic [3:0] ex_alu;
  write_back_mux_selector ex_wb;
  logic hold;
  logic [CW-1:0] cnt;

  id_ex_stage_reg #(.XLEN(32), .ALU_CTRL_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_valid), .id_opcode_ip(id_opcode),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_rd_ip(id_rd),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2),
    .id_imm_ip(id_imm), .id_pc_ip(id_pc),
    .id_alu_ctrl_ip(id_alu), .id_wb_mux_ip(id_wb),
    .ex_flush_ip(flush), .mem_stall_ip(stall),
    .ex_valid_op(ex_valid), .ex_opcode_op(ex_opcode),
    .ex_rs1_op(ex_rs1), .ex_rs2_op(ex_rs2), .ex_rd_op(ex_rd),
    .ex_rs1_data_op(ex_d1), .ex_rs2_data_op(ex_d2),
    .ex_imm_op(ex_imm), .ex_pc_op(ex_pc),
    .ex_alu_ctrl_op(ex_alu), .ex_wb_mux_op(ex_wb),
    .id_hold_op(hold), .load_use_cnt_op(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit [6:0] op;
    bit [4:0] rs1, rs2, rd;
    bit [31:0] d1, d2, imm, pc;
    bit [3:0] alu;
    bit [1:0] wb;
    int cnt;
  } slot_t;

  slot_t ex_q[$];
  bit hold_q[$];
  slot_t m;
  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  function automatic bit reads_rs1(bit [6:0] op);
    return op == OPCODE_OP || op == OPCODE_OPIMM || op == OPCODE_LOAD
        || op == OPCODE_STORE || op == OPCODE_BRANCH || op == OPCODE_JALR;
  endfunction

  function automatic bit reads_rs2(bit [6:0] op);
    return op == OPCODE_OP || op == OPCODE_STORE || op == OPCODE_BRANCH;
  endfunction

  function automatic slot_t empty_slot(int c);
    slot_t b;
    b = '{default: 0};
    b.cnt = c;
    return b;
  endfunction

  task automatic step(input bit rst, input bit fl, input bit st,
                      input bit v, input bit [6:0] op,
                      input bit [4:0] r1, input bit [4:0] r2,
                      input bit [4:0] rd, input bit [31:0] d1,
                      input bit [31:0] d2, input bit [31:0] imm,
                      input bit [31:0] pc, input bit [3:0] alu,
                      input bit [1:0] wb);
    bit lu;
    slot_t n;
    @(negedge clk);
    reset = rst; flush = fl; stall = st;
    id_valid = v; id_opcode = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_d1 = d1; id_d2 = d2; id_imm = imm; id_pc = pc;
    id_alu = alu; id_wb = write_back_mux_selector'(wb);
    lu = m.v && m.wb == 2'(MEM_WRITEBACK) && m.rd != 0 && v
      && ((reads_rs1(op) && r1 == m.rd) || (reads_rs2(op) && r2 == m.rd));
    hold_q.push_back(!rst && !fl && (lu || st));
    if (rst) n = empty_slot(0);
    else if (fl) n = empty_slot(m.cnt);
    else if (st) n = m;
    else if (lu) n = empty_slot(m.cnt < (1 << CW) - 1 ? m.cnt + 1 : m.cnt);
    else if (!v) n = empty_slot(m.cnt);
    else begin
      n = '{1'b1, op, r1, r2, rd, d1, d2, imm, pc, alu, wb, m.cnt};
    end
    ex_q.push_back(n);
    m = n;
  endtask

  task automatic op_step(input bit fl, input bit st, input bit [6:0] op,
                         input bit [4:0] r1, input bit [4:0] r2,
                         input bit [4:0] rd, input bit [1:0] wb);
    step(1'b0, fl, st, 1'b1, op, r1, r2, rd, $urandom, $urandom,
         $urandom, $urandom, 4'($urandom), wb);
  endtask

  task automatic rand_step();
    bit [6:0] ops [10];
    ops = '{OPCODE_LOAD, OPCODE_OPIMM, OPCODE_AUIPC, OPCODE_STORE,
            OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR,
            OPCODE_JAL, OPCODE_SYSTEM};
    step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
         $urandom_range(0, 6) == 0, $urandom_range(0, 4) != 0,
         ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         $urandom, $urandom, $urandom, $urandom, 4'($urandom),
         $urandom_range(0, 1) ? 2'(MEM_WRITEBACK) : 2'($urandom));
  endtask

  initial begin : ex_monitor
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        chk("ex_valid", ex_valid, e.v);
        chk("ex_opcode", ex_opcode, e.op);
        chk("ex_rs1", ex_rs1, e.rs1);
        chk("ex_rs2", ex_rs2, e.rs2);
        chk("ex_rd", ex_rd, e.rd);
        chk("ex_rs1_data", ex_d1, e.d1);
        chk("ex_rs2_data", ex_d2, e.d2);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_alu_ctrl", ex_alu, e.alu);
        chk("ex_wb_mux", ex_wb, e.wb);
        chk("load_use_cnt", cnt, e.cnt);
      end
    end
  end

  initial begin : hold_monitor
    bit h;
    forever begin
      @(negedge clk);
      #2;
      if (hold_q.size() > 0) begin
        h = hold_q.pop_front();
        chk("id_hold", hold, h);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    id_valid = 1'b0; id_opcode = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_d1 = '0; id_d2 = '0; id_imm = '0; id_pc = '0;
    id_alu = '0; id_wb = NO_WRITEBACK;
    m = empty_slot(0);

    repeat (2) step(1'b1, 0, 0, 1'b1, OPCODE_OP, 1, 2, 3,
                    32'h11, 32'h22, 32'h33, 32'h44, 4'h5, 2'(ALU_WRITEBACK));
    op_step(0, 0, OPCODE_OP, 1, 2, 3, 2'(ALU_WRITEBACK));

    op_step(0, 0, OPCODE_LOAD, 2, 0, 5, 2'(MEM_WRITEBACK));
    op_step(0, 0, OPCODE_OP, 5, 7, 8, 2'(ALU_WRITEBACK));
    op_step(0, 0, OPCODE_OP, 5, 7, 8, 2'(ALU_WRITEBACK));

    op_step(0, 0, OPCODE_LOAD, 2, 0, 0, 2'(MEM_WRITEBACK));
    op_step(0, 0, OPCODE_OP, 0, 4, 9, 2'(ALU_WRITEBACK));
    op_step(0, 0, OPCODE_LOAD, 2, 0, 6, 2'(MEM_WRITEBACK));
    op_step(0, 0, OPCODE_OPIMM, 1, 6, 9, 2'(ALU_WRITEBACK));

    op_step(0, 0, OPCODE_LOAD, 2, 0, 5, 2'(MEM_WRITEBACK));
    op_step(1, 1, OPCODE_OP, 5, 5, 8, 2'(ALU_WRITEBACK));

    op_step(0, 0, OPCODE_OP, 1, 2, 10, 2'(ALU_WRITEBACK));
    repeat (3) op_step(0, 1, 7'($urandom), 5'($urandom),
                       5'($urandom), 5'($urandom), 2'($urandom));
    op_step(0, 0, OPCODE_STORE, 3, 4, 0, 2'(NO_WRITEBACK));

    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      op_step(0, 0, OPCODE_LOAD, 1, 0, 3, 2'(MEM_WRITEBACK));
      op_step(0, 0, OPCODE_BRANCH, 9, 3, 0, 2'(NO_WRITEBACK));
    end

    for (int i = 0; i < 600; i++) rand_step();

    @(negedge clk);
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 4 && (ex_q.size() > 0 || hold_q.size() > 0); i++)
      @(negedge clk);
    if (ex_q.size() > 0 || hold_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               ex_q.size() + hold_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
